// File: rtl/fnd_scan_ctrl.sv
// Four-digit 7-segment scan controller: binary count -> multiplexed BCD digit + active-low digit commons.
// Latency: outputs are registered and change only on scan ticks; input reaches display at the next frame wrap.
// Backpressure: none; free-running scan, count_data may change on any cycle.
//
// Ports:
//   clk, rst_n   system clock (rising edge), asynchronous active-low reset
//   count_data   14-bit binary value to display (values >= 10000 saturate to 9999)
//   lz_blank     1 = blank leading zeros
//   bcd          current digit value 0..9, to the segment decoder
//   fnd_com      active-low digit select, bit0 = ones .. bit3 = thousands
//   ovf          1 = current frame snapshot was saturated
module fnd_scan_ctrl #(
  parameter int SYS_CLK_HZ = 100_000_000,
  parameter int SCAN_HZ    = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] count_data,
  input  logic        lz_blank,
  output logic [3:0]  bcd,
  output logic [3:0]  fnd_com,
  output logic        ovf
);

  localparam int DIV = SYS_CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [13:0]   MAX_VAL  = 14'd9999;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [13:0]   snap_q, snap_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    bcd_q, bcd_d;
  logic [3:0]    fnd_com_q, fnd_com_d;

  logic          tick;
  logic          in_ovf;
  logic [13:0]   in_sat;
  logic [13:0]   disp_val;
  logic [13:0]   place;
  logic          blank;

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    in_ovf    = (count_data > MAX_VAL);
    in_sat    = in_ovf ? MAX_VAL : count_data;

    div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
    idx_d     = idx_q;
    snap_d    = snap_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    fnd_com_d = fnd_com_q;

    if (tick) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        snap_d = in_sat;
        ovf_d  = in_ovf;
      end
    end

    // On the frame-wrap tick the ones digit must come from the value being
    // snapshotted now, not from the previous frame's snapshot.
    disp_val = (idx_q == 2'd3) ? in_sat : snap_q;

    case (idx_d)
      2'd0:    place = 14'd1;
      2'd1:    place = 14'd10;
      2'd2:    place = 14'd100;
      default: place = 14'd1000;
    endcase

    // Digit k is a leading zero exactly when the value is below 10^k.
    blank = lz_blank && (idx_d != 2'd0) && (disp_val < place);

    if (tick) begin
      bcd_d     = 4'((disp_val / place) % 14'd10);
      fnd_com_d = blank ? 4'b1111 : ~(4'b0001 << idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      idx_q     <= 2'd3;
      snap_q    <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= 4'd0;
      fnd_com_q <= 4'b1111;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      fnd_com_q <= fnd_com_d;
    end
  end

  assign bcd     = bcd_q;
  assign fnd_com = fnd_com_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl with DIV = 4.
// Reference model: edge counter since reset release, frame/slot bookkeeping and
// decimal arithmetic on the per-frame snapshot.
module tb_fnd_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [13:0] count_data;
  logic        lz_blank;
  logic [3:0]  bcd;
  logic [3:0]  fnd_com;
  logic        ovf;

  int n_pass;
  int n_checks;

  // model state
  int          n_edge;
  int          m_slot;
  int          m_snap;
  logic        m_ovf;
  logic [3:0]  e_bcd;
  logic [3:0]  e_com;
  logic        e_ovf;

  fnd_scan_ctrl #(.SYS_CLK_HZ(8), .SCAN_HZ(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_data (count_data),
    .lz_blank   (lz_blank),
    .bcd        (bcd),
    .fnd_com    (fnd_com),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    n_edge = 0;
    m_slot = 3;
    m_snap = 0;
    m_ovf  = 1'b0;
    e_bcd  = 4'd0;
    e_com  = 4'b1111;
    e_ovf  = 1'b0;
  endtask

  // One clock edge; the model sees the inputs present just before the edge.
  task automatic advance();
    int cd;
    logic lz;
    int p;
    logic [3:0] onehot;
    cd = int'(count_data);
    lz = lz_blank;
    @(posedge clk);
    #1;
    n_edge++;
    if (n_edge % 4 == 0) begin
      m_slot = (m_slot + 1) % 4;
      if (m_slot == 0) begin
        m_snap = (cd > 9999) ? 9999 : cd;
        m_ovf  = (cd > 9999);
      end
      p = 1;
      for (int k = 0; k < m_slot; k++) p = p * 10;
      e_bcd  = 4'((m_snap / p) % 10);
      onehot = 4'b0001 << m_slot;
      e_com  = (lz && m_slot != 0 && m_snap < p) ? 4'b1111 : ~onehot;
      e_ovf  = m_ovf;
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    count_data = 14'd0;
    lz_blank   = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({fnd_com, bcd, ovf} !== {4'b1111, 4'd0, 1'b0})
        $display("FAIL reset_hold: got com=%b bcd=%0d ovf=%b want com=1111 bcd=0 ovf=0", fnd_com, bcd, ovf);
      else n_pass++;
    end
    #2 rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 4; i++) begin
      advance();
      n_checks++;
      if (i < 4 && fnd_com !== 4'b1111)
        $display("FAIL first_tick_early edge %0d: got com=%b want 1111", i, fnd_com);
      else if (i == 4 && {fnd_com, bcd} !== {4'b1110, 4'd0})
        $display("FAIL first_tick: got com=%b bcd=%0d want com=1110 bcd=0", fnd_com, bcd);
      else n_pass++;
    end
  endtask

  task automatic run_cmp(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      advance();
      n_checks++;
      if ({fnd_com, bcd, ovf} !== {e_com, e_bcd, e_ovf})
        $display("FAIL %s edge %0d: got com=%b bcd=%0d ovf=%b want com=%b bcd=%0d ovf=%b",
                 name, n_edge, fnd_com, bcd, ovf, e_com, e_bcd, e_ovf);
      else n_pass++;
    end
  endtask

  task automatic test_normal_scan();
    count_data = 14'd1234;
    lz_blank   = 1'b0;
    run_cmp("normal_scan", 40);
  endtask

  task automatic test_lz_blank();
    count_data = 14'd7;
    lz_blank   = 1'b1;
    run_cmp("lz_blank_7", 36);
    count_data = 14'd0;
    run_cmp("lz_blank_0", 36);
    count_data = 14'd305;
    run_cmp("lz_blank_305", 36);
    lz_blank   = 1'b0;
    run_cmp("lz_off_305", 36);
  endtask

  task automatic test_saturation();
    count_data = 14'd12000;
    run_cmp("sat_12000", 36);
    n_checks++;
    if (ovf !== 1'b1) $display("FAIL sat_ovf: got ovf=%b want 1", ovf);
    else n_pass++;
    count_data = 14'd9999;
    run_cmp("sat_9999", 36);
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL no_ovf_9999: got ovf=%b want 0", ovf);
    else n_pass++;
    count_data = 14'd16383;
    run_cmp("sat_16383", 36);
  endtask

  task automatic test_midframe_change();
    count_data = 14'd1234;
    lz_blank   = 1'b0;
    run_cmp("mid_pre", 20);
    // advance to the first edge where the tens digit becomes current
    for (int i = 0; i < 20 && !(m_slot == 1 && n_edge % 4 == 0); i++)
      run_cmp("mid_sync", 1);
    n_checks++;
    if (!(m_slot == 1 && n_edge % 4 == 0)) $display("FAIL mid_sync_timeout: slot=%0d", m_slot);
    else n_pass++;
    #1 count_data = 14'd5678;
    run_cmp("mid_change", 40);
  endtask

  task automatic test_async_reset();
    count_data = 14'd1234;
    lz_blank   = 1'b0;
    for (int i = 0; i < 20 && !(m_slot == 2 && n_edge % 4 == 1); i++)
      run_cmp("arst_sync", 1);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fnd_com, bcd, ovf} !== {4'b1111, 4'd0, 1'b0})
      $display("FAIL async_reset: got com=%b bcd=%0d ovf=%b want com=1111 bcd=0 ovf=0", fnd_com, bcd, ovf);
    else n_pass++;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    run_cmp("after_arst", 36);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: count_data = 14'($urandom_range(0, 9));
        1: count_data = 14'($urandom_range(0, 999));
        2: count_data = 14'($urandom_range(0, 9999));
        default: count_data = 14'($urandom_range(9990, 16383));
      endcase
      lz_blank = 1'($urandom_range(0, 1));
      run_cmp("random", int'($urandom_range(1, 18)));
    end
  endtask

  initial begin
    n_pass   = 0;
    n_checks = 0;
    test_reset();
    test_normal_scan();
    test_lz_blank();
    test_saturation();
    test_midframe_change();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
